axi_lite_regbank: RTL and testbench

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

---
 rtl/axi_lite_regbank_if.sv | 37 +++
 rtl/axi_lite_regbank.sv | 183 ++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank: the AW, W, B, AR and R channels.
interface axi_lite_regbank_if #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
);
  logic               axi_lite_awvalid;
  logic               axi_lite_awready;
  logic [ASIZE-1:0]   axi_lite_awaddr;
  logic               axi_lite_wvalid;
  logic               axi_lite_wready;
  logic [DSIZE-1:0]   axi_lite_wdata;
  logic [DSIZE/8-1:0] axi_lite_wstrb;
  logic               axi_lite_bvalid;
  logic               axi_lite_bready;
  logic [1:0]         axi_lite_bresp;
  logic               axi_lite_arvalid;
  logic               axi_lite_arready;
  logic [ASIZE-1:0]   axi_lite_araddr;
  logic               axi_lite_rvalid;
  logic               axi_lite_rready;
  logic [DSIZE-1:0]   axi_lite_rdata;
  logic [1:0]         axi_lite_rresp;

  modport master (
    output axi_lite_awvalid, axi_lite_awaddr, axi_lite_wvalid, axi_lite_wdata, axi_lite_wstrb,
    output axi_lite_bready, axi_lite_arvalid, axi_lite_araddr, axi_lite_rready,
    input  axi_lite_awready, axi_lite_wready, axi_lite_bvalid, axi_lite_bresp,
    input  axi_lite_arready, axi_lite_rvalid, axi_lite_rdata, axi_lite_rresp
  );

  modport slave (
    input  axi_lite_awvalid, axi_lite_awaddr, axi_lite_wvalid, axi_lite_wdata, axi_lite_wstrb,
    input  axi_lite_bready, axi_lite_arvalid, axi_lite_araddr, axi_lite_rready,
    output axi_lite_awready, axi_lite_wready, axi_lite_bvalid, axi_lite_bresp,
    output axi_lite_arready, axi_lite_rvalid, axi_lite_rdata, axi_lite_rresp
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank with independent AW/W holding slots and a concurrent read path.
// Define AXI_LITE_REGBANK_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regbank #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREG  = 16
) (
  input  logic                   axi_lite_aclk,
  input  logic                   axi_lite_rst,
  axi_lite_regbank_if.slave      axi,
  output logic [NREG*DSIZE-1:0]  reg_q,
  output logic [NREG-1:0]        reg_wr_pulse
);

  localparam int SW  = DSIZE / 8;
  localparam int LSB = $clog2(SW);
  localparam int WW  = ASIZE - LSB;
  localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [WW-1:0] NREG_W = WW'(NREG);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_LITE_REGBANK_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  function automatic logic [1:0] resp_for(input logic in_range);
    return (ERR_EN && !in_range) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic logic [DSIZE-1:0] merge_bytes(input logic [DSIZE-1:0] old_v,
                                                   input logic [DSIZE-1:0] new_v,
                                                   input logic [SW-1:0]    strb);
    logic [DSIZE-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic             aw_full_q, aw_full_d;
  logic [ASIZE-1:0] aw_addr_q, aw_addr_d;
  logic             w_full_q, w_full_d;
  logic [DSIZE-1:0] w_data_q, w_data_d;
  logic [SW-1:0]    w_strb_q, w_strb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [NREG-1:0]  pulse_q, pulse_d;
  logic [DSIZE-1:0] regs_q [NREG];
  logic [DSIZE-1:0] regs_d [NREG];

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic [SW-1:0]    wr_strb;
  logic             wr_ok, rd_ok;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             unused_addr_lsbs;

  // Readies are gated by reset so they are low for the whole reset window.
  assign awready = !axi_lite_rst && !aw_full_q && !bvalid_q;
  assign wready  = !axi_lite_rst && !w_full_q && !bvalid_q;
  assign arready = !axi_lite_rst && !rvalid_q;

  assign aw_hs  = axi.axi_lite_awvalid && awready;
  assign w_hs   = axi.axi_lite_wvalid && wready;
  assign ar_hs  = axi.axi_lite_arvalid && arready;
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs);

  // A held slot takes priority; otherwise the beat handshaking this cycle is used.
  assign wr_addr = aw_full_q ? aw_addr_q : axi.axi_lite_awaddr;
  assign wr_data = w_full_q ? w_data_q : axi.axi_lite_wdata;
  assign wr_strb = w_full_q ? w_strb_q : axi.axi_lite_wstrb;

  assign wr_ok  = wr_addr[ASIZE-1:LSB] < NREG_W;
  assign rd_ok  = axi.axi_lite_araddr[ASIZE-1:LSB] < NREG_W;
  assign wr_idx = wr_addr[LSB +: IW];
  assign rd_idx = axi.axi_lite_araddr[LSB +: IW];
  assign unused_addr_lsbs = ^{wr_addr[LSB-1:0], axi.axi_lite_araddr[LSB-1:0]};

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = resp_for(wr_ok);
      if (wr_ok) begin
        pulse_d[wr_idx] = 1'b1;
        regs_d[wr_idx]  = merge_bytes(regs_q[wr_idx], wr_data, wr_strb);
      end
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = axi.axi_lite_awaddr;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = axi.axi_lite_wdata;
        w_strb_d = axi.axi_lite_wstrb;
      end
    end

    if (bvalid_q && axi.axi_lite_bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end

    // Read samples regs_q, so a same-edge write to the same register returns the old value.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
      rresp_d  = resp_for(rd_ok);
    end else if (rvalid_q && axi.axi_lite_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
    end
  end

  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  assign axi.axi_lite_awready = awready;
  assign axi.axi_lite_wready  = wready;
  assign axi.axi_lite_arready = arready;
  assign axi.axi_lite_bvalid  = bvalid_q;
  assign axi.axi_lite_bresp   = bresp_q;
  assign axi.axi_lite_rvalid  = rvalid_q;
  assign axi.axi_lite_rdata   = rdata_q;
  assign axi.axi_lite_rresp   = rresp_q;
  assign reg_wr_pulse         = pulse_q;

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign reg_q[i*DSIZE +: DSIZE] = regs_q[i];
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: vector table, multi-cycle corner sequences, and randomized
// traffic checked against an array-based register model.
module tb_axi_lite_regbank;
  // A 28-bit address bus drops the top nibble of 0x1000_0008, leaving register 2.
  localparam int ASIZE = 28;
  localparam int DSIZE = 32;
  localparam int NREG  = 16;
`ifdef AXI_LITE_REGBANK_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [NREG*DSIZE-1:0] reg_q;
  logic [NREG-1:0]       reg_wr_pulse;

  axi_lite_regbank_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

  axi_lite_regbank #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREG(NREG)) dut (
    .axi_lite_aclk (clk),
    .axi_lite_rst  (rst),
    .axi           (bus),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [NREG];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [ASIZE-1:0] t;
    t = a[ASIZE-1:0];
    return int'(t / 4) < NREG;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [ASIZE-1:0] t;
    t = a[ASIZE-1:0];
    return int'(t / 4);
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  function automatic logic [NREG*DSIZE-1:0] mdl_flat();
    logic [NREG*DSIZE-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = mdl[i];
    return f;
  endfunction

  function automatic logic [NREG-1:0] exp_pulse(input logic [31:0] a);
    logic [NREG-1:0] p;
    p = '0;
    if (in_rng(a)) p[widx(a)] = 1'b1;
    return p;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (ERR && !in_rng(a)) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_rng(a) ? mdl[widx(a)] : 32'h0;
  endfunction

  // Tasks start and end just after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, output logic [1:0] resp, output logic [NREG-1:0] pls);
    bit aw_pend, w_pend, hs_aw, hs_w;
    int n;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    n = 0;
    bus.axi_lite_awaddr  = a[ASIZE-1:0];
    bus.axi_lite_wdata   = d;
    bus.axi_lite_wstrb   = s;
    bus.axi_lite_awvalid = 1'b1;
    bus.axi_lite_wvalid  = 1'b1;
    while ((aw_pend || w_pend) && n < 20) begin
      @(negedge clk);
      hs_aw = bus.axi_lite_awvalid && bus.axi_lite_awready;
      hs_w  = bus.axi_lite_wvalid && bus.axi_lite_wready;
      @(posedge clk); #1;
      if (hs_aw) begin bus.axi_lite_awvalid = 1'b0; aw_pend = 1'b0; end
      if (hs_w)  begin bus.axi_lite_wvalid  = 1'b0; w_pend  = 1'b0; end
      n++;
    end
    chk("wr_accept_timeout", {aw_pend, w_pend}, 2'b00);
    bus.axi_lite_awvalid = 1'b0;
    bus.axi_lite_wvalid  = 1'b0;
    @(negedge clk);
    chk("b_latency", bus.axi_lite_bvalid, 1'b1);
    resp = bus.axi_lite_bresp;
    pls  = reg_wr_pulse;
    for (int i = 0; i < bdly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("b_hold", {bus.axi_lite_bvalid, bus.axi_lite_bresp, reg_wr_pulse}, {1'b1, resp, 16'h0});
    end
    bus.axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0;
    @(negedge clk);
    chk("b_clear", bus.axi_lite_bvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit pend, hs;
    int n;
    pend = 1'b1;
    n = 0;
    bus.axi_lite_araddr  = a[ASIZE-1:0];
    bus.axi_lite_arvalid = 1'b1;
    while (pend && n < 20) begin
      @(negedge clk);
      hs = bus.axi_lite_arvalid && bus.axi_lite_arready;
      @(posedge clk); #1;
      if (hs) begin bus.axi_lite_arvalid = 1'b0; pend = 1'b0; end
      n++;
    end
    chk("ar_accept_timeout", pend, 1'b0);
    bus.axi_lite_arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", bus.axi_lite_rvalid, 1'b1);
    data = bus.axi_lite_rdata;
    resp = bus.axi_lite_rresp;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); @(negedge clk);
      chk("r_hold", {bus.axi_lite_rvalid, bus.axi_lite_rdata, bus.axi_lite_rresp}, {1'b1, data, resp});
    end
    bus.axi_lite_rready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_rready = 1'b0;
    @(negedge clk);
    chk("r_clear", bus.axi_lite_rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [15:0] pulse;
    logic        oor;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [1:0]      resp, rr;
    logic [NREG-1:0] pls;
    logic [31:0]     rd, old5, a, d;
    logic [3:0]      s;

    vecs[0] = '{32'h1000_0008, 32'hDEADBEEF, 4'hF, 32'h08, 32'hDEADBEEF, 16'h0004, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'hFFFFFFFF, 4'hF, 32'h04, 32'hFFFFFFFF, 16'h0002, 1'b0};
    vecs[2] = '{32'h0000_0004, 32'h0000AA00, 4'h2, 32'h04, 32'hFFFFAAFF, 16'h0002, 1'b0};
    vecs[3] = '{32'h0000_000B, 32'h11223344, 4'h9, 32'h08, 32'h11ADBE44, 16'h0004, 1'b0};
    vecs[4] = '{32'h0000_003C, 32'h55667788, 4'h0, 32'h3C, 32'h00000000, 16'h8000, 1'b0};
    vecs[5] = '{32'h0000_0040, 32'hABCDABCD, 4'hF, 32'h40, 32'h00000000, 16'h0000, 1'b1};
    vecs[6] = '{32'h0000_003C, 32'hA5A5A5A5, 4'hF, 32'h3C, 32'hA5A5A5A5, 16'h8000, 1'b0};

    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    rst = 1'b1;
    bus.axi_lite_awvalid = 1'b0; bus.axi_lite_awaddr = '0;
    bus.axi_lite_wvalid  = 1'b0; bus.axi_lite_wdata  = '0; bus.axi_lite_wstrb = '0;
    bus.axi_lite_bready  = 1'b0;
    bus.axi_lite_arvalid = 1'b0; bus.axi_lite_araddr = '0;
    bus.axi_lite_rready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_arready,
                     bus.axi_lite_bvalid, bus.axi_lite_rvalid, bus.axi_lite_bresp,
                     bus.axi_lite_rresp, reg_wr_pulse}, '0);
    chk("rst_data", {bus.axi_lite_rdata, reg_q}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_arready}, 3'b111);
    @(posedge clk); #1;

    // Vector table: write then read back
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, i % 3, resp, pls);
      chk($sformatf("vec%0d_bresp", i), resp, (vecs[i].oor && ERR) ? 2'b10 : 2'b00);
      chk($sformatf("vec%0d_pulse", i), pls, vecs[i].pulse);
      mdl_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
      chk($sformatf("vec%0d_regs", i), reg_q, mdl_flat());
      axi_read(vecs[i].raddr, i % 2, rd, rr);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_rresp", i), rr, (vecs[i].oor && ERR) ? 2'b10 : 2'b00);
    end

    // W three cycles ahead of AW
    bus.axi_lite_wdata = 32'h12345678; bus.axi_lite_wstrb = 4'hF; bus.axi_lite_wvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", bus.axi_lite_wready, 1'b1);
    @(posedge clk); #1;
    bus.axi_lite_wvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_wready_drop", {bus.axi_lite_wready, bus.axi_lite_awready, bus.axi_lite_bvalid}, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.axi_lite_awaddr = 'h04; bus.axi_lite_awvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_aw_pre", {bus.axi_lite_awready, bus.axi_lite_bvalid}, 2'b10);
    @(posedge clk); #1;
    bus.axi_lite_awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_b", {bus.axi_lite_bvalid, reg_wr_pulse}, {1'b1, 16'h0002});
    chk("wfirst_reg1", reg_q[63:32], 32'h12345678);
    mdl_write(32'h04, 32'h12345678, 4'hF);
    bus.axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0;

    // B back-pressure blocks a second write
    bus.axi_lite_awaddr = 'h0C; bus.axi_lite_wdata = 32'h0BADF00D; bus.axi_lite_wstrb = 4'hF;
    bus.axi_lite_awvalid = 1'b1; bus.axi_lite_wvalid = 1'b1;
    @(negedge clk);
    chk("bstall_accept", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_bvalid}, 3'b110);
    @(posedge clk); #1;
    mdl_write(32'h0C, 32'h0BADF00D, 4'hF);
    bus.axi_lite_awaddr = 'h10; bus.axi_lite_wdata = 32'h600DCAFE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bstall_c%0d", i), {bus.axi_lite_bvalid, bus.axi_lite_awready, bus.axi_lite_wready}, 3'b100);
      @(posedge clk); #1;
    end
    chk("bstall_no_second", reg_q, mdl_flat());
    bus.axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0;
    @(negedge clk);
    chk("bstall_release", {bus.axi_lite_bvalid, bus.axi_lite_awready, bus.axi_lite_wready}, 3'b011);
    @(posedge clk); #1;
    bus.axi_lite_awvalid = 1'b0; bus.axi_lite_wvalid = 1'b0;
    mdl_write(32'h10, 32'h600DCAFE, 4'hF);
    @(negedge clk);
    chk("bstall_second_b", {bus.axi_lite_bvalid, reg_wr_pulse}, {1'b1, 16'h0010});
    chk("bstall_second_regs", reg_q, mdl_flat());
    bus.axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0;

    // Read and write of the same register on the same edge
    old5 = mdl[5];
    bus.axi_lite_awaddr = 'h14; bus.axi_lite_wdata = 32'hCAFE0005; bus.axi_lite_wstrb = 4'hF;
    bus.axi_lite_araddr = 'h14;
    bus.axi_lite_awvalid = 1'b1; bus.axi_lite_wvalid = 1'b1; bus.axi_lite_arvalid = 1'b1;
    @(negedge clk);
    chk("rw_same_ready", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_arready}, 3'b111);
    @(posedge clk); #1;
    bus.axi_lite_awvalid = 1'b0; bus.axi_lite_wvalid = 1'b0; bus.axi_lite_arvalid = 1'b0;
    mdl_write(32'h14, 32'hCAFE0005, 4'hF);
    @(negedge clk);
    chk("rw_same_rdata_old", {bus.axi_lite_rvalid, bus.axi_lite_rdata}, {1'b1, old5});
    chk("rw_same_write", {bus.axi_lite_bvalid, reg_q}, {1'b1, mdl_flat()});
    bus.axi_lite_bready = 1'b1; bus.axi_lite_rready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0; bus.axi_lite_rready = 1'b0;

    // Reset with W held and R pending
    bus.axi_lite_wdata = 32'hBAD0BAD0; bus.axi_lite_wstrb = 4'hF; bus.axi_lite_wvalid = 1'b1;
    bus.axi_lite_araddr = 'h08; bus.axi_lite_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.axi_lite_wvalid = 1'b0; bus.axi_lite_arvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_held", {bus.axi_lite_rvalid, bus.axi_lite_wready}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_in_reset", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_arready,
                             bus.axi_lite_bvalid, bus.axi_lite_rvalid, bus.axi_lite_rdata, reg_q}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    @(negedge clk);
    chk("mid_rst_after", {bus.axi_lite_bvalid, bus.axi_lite_rvalid, reg_q}, '0);
    chk("mid_rst_ready", {bus.axi_lite_awready, bus.axi_lite_wready, bus.axi_lite_arready}, 3'b111);
    @(posedge clk); #1;
    bus.axi_lite_awaddr = 'h00; bus.axi_lite_awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.axi_lite_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("no_ghost_commit%0d", i), {bus.axi_lite_bvalid, reg_wr_pulse, reg_q}, '0);
      @(posedge clk); #1;
    end
    bus.axi_lite_wdata = 32'h00000777; bus.axi_lite_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.axi_lite_wvalid = 1'b0;
    mdl_write(32'h00, 32'h00000777, 4'hF);
    @(negedge clk);
    chk("post_rst_write", {bus.axi_lite_bvalid, reg_q}, {1'b1, mdl_flat()});
    bus.axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_lite_bready = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = ($urandom_range(0, NREG - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), resp, pls);
        chk("rnd_bresp", resp, exp_resp(a));
        chk("rnd_pulse", pls, exp_pulse(a));
        mdl_write(a, d, s);
        chk("rnd_regs", reg_q, mdl_flat());
      end else begin
        axi_read(a, $urandom_range(0, 3), rd, rr);
        chk("rnd_rdata", rd, exp_rdata(a));
        chk("rnd_rresp", rr, exp_resp(a));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
